// File: rtl/max7219_pkg.sv
// max7219_pkg: MAX7219 register addresses, FSM state encodings and init-word helper
package max7219_pkg;
    localparam logic [7:0] REG_NOOP       = 8'h00;
    localparam logic [7:0] REG_DIGIT0     = 8'h01;
    localparam logic [7:0] REG_DECODE     = 8'h09;
    localparam logic [7:0] REG_INTENSITY  = 8'h0A;
    localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
    localparam logic [7:0] REG_TEST       = 8'h0F;

    typedef enum logic [5:0] {
        ST_WAIT  = 6'd0,
        ST_INIT  = 6'd1,
        ST_SCAN  = 6'd2,
        ST_LOAD  = 6'd3,
        ST_SHIFT = 6'd4,
        ST_GAP   = 6'd5,
        ST_IDLE  = 6'd6
    } state_t;

    // Word broadcast at each of the six init steps: shutdown, test off, decode, scan limit, intensity, wake.
    function automatic logic [15:0] init_word(input logic [2:0] step, input logic [7:0] dec,
                                              input logic [7:0] lim, input logic [7:0] inten);
        return step == 3'd0 ? {REG_SHUTDOWN, 8'h00} :
               step == 3'd1 ? {REG_TEST, 8'h00} :
               step == 3'd2 ? {REG_DECODE, dec} :
               step == 3'd3 ? {REG_SCAN_LIMIT, lim} :
               step == 3'd4 ? {REG_INTENSITY, inten} : {REG_SHUTDOWN, 8'h01};
    endfunction
endpackage

// File: rtl/max7219_chain_if.sv
// max7219_chain_if: user write port, status and board pins of the MAX7219 chain driver
// master = user logic/bench, slave = max7219_chain; intensity_in exists only with MAX7219_INTENSITY_PORT_EN
interface max7219_chain_if;
    logic       wr_en;
    logic [2:0] wr_dev;
    logic [2:0] wr_digit;
    logic [7:0] wr_data;
`ifdef MAX7219_INTENSITY_PORT_EN
    logic [3:0] intensity_in;
`endif
    logic       init_done;
    logic       busy;
    logic [5:0] state_dbg;
    logic       io_din;
    logic       io_cs;
    logic       io_clk;

    modport master (
        output wr_en, wr_dev, wr_digit, wr_data,
`ifdef MAX7219_INTENSITY_PORT_EN
        output intensity_in,
`endif
        input init_done, busy, state_dbg, io_din, io_cs, io_clk
    );

    modport slave (
        input wr_en, wr_dev, wr_digit, wr_data,
`ifdef MAX7219_INTENSITY_PORT_EN
        input intensity_in,
`endif
        output init_done, busy, state_dbg, io_din, io_cs, io_clk
    );
endinterface

// File: rtl/max7219_shifter.sv
// max7219_shifter: serial tick generator and NUM_DEVICES*16-bit frame serializer
// ports: clk/rst, i_start+i_data (sampled on a tick while idle), o_tick, o_busy, o_done (gap-end tick), o_din/o_cs/o_clk pins
module max7219_shifter #(
    parameter int NUM_DEVICES = 1,
    parameter int CLK_DIV     = 1350
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [16*NUM_DEVICES-1:0]  i_data,
    output logic                       o_tick,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_din,
    output logic                       o_cs,
    output logic                       o_clk
);
    localparam int W     = 16 * NUM_DEVICES;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int LAST  = 2 * W + 3;

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_cnt;
    logic [W-1:0]     r_sr;
    logic             r_act, r_din, r_cs, r_clk;
    logic             w_tick;

    assign w_tick = r_div == DIV_W'(CLK_DIV - 1);
    assign o_tick = w_tick;
    assign o_busy = r_act;
    assign o_done = w_tick && r_act && r_cnt == 10'(LAST);
    assign o_din  = r_din;
    assign o_cs   = r_cs;
    assign o_clk  = r_clk;

    // r_cnt holds the index of the current tick within the frame: even = data/clk low, odd = clk high,
    // 2W = trailing clk low, 2W+1 = cs rises, 2W+3 = end of the latch gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_act <= 1'b0;
            r_cnt <= '0;
            r_sr  <= '0;
            r_din <= 1'b0;
            r_cs  <= 1'b1;
            r_clk <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (!r_act) begin
                    if (i_start) begin
                        r_act <= 1'b1;
                        r_cnt <= 10'd1;
                        r_sr  <= i_data << 1;
                        r_din <= i_data[W-1];
                        r_cs  <= 1'b0;
                        r_clk <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt < 10'(2 * W)) begin
                        r_clk <= r_cnt[0];
                        if (!r_cnt[0]) begin
                            r_din <= r_sr[W-1];
                            r_sr  <= r_sr << 1;
                        end
                    end else begin
                        r_clk <= 1'b0;
                        if (r_cnt == 10'(2 * W + 1)) r_cs <= 1'b1;
                        if (r_cnt == 10'(LAST)) r_act <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/max7219_chain.sv
// max7219_chain: MAX7219 daisy-chain driver with init sequence, frame buffer and dirty-row refresh
// ports: clk, rst (sync, active high), bus (slave: write port in; init_done/busy/state_dbg/io_* out)
// optional: MAX7219_INTENSITY_PORT_EN adds bus.intensity_in and runtime intensity updates
module max7219_chain
    import max7219_pkg::*;
#(
    parameter int         NUM_DEVICES  = 1,
    parameter int         CLK_DIV      = 1350,
    parameter int         STARTUP_WAIT = 20,
    parameter logic [7:0] DECODE_MODE  = 8'h00,
    parameter logic [7:0] SCAN_LIMIT   = 8'h07,
    parameter logic [7:0] INTENSITY    = 8'h00
) (
    input logic            clk,
    input logic            rst,
    max7219_chain_if.slave bus
);
    localparam int W = 16 * NUM_DEVICES;

    state_t       r_state;
    logic [15:0]  r_wcnt;
    logic [2:0]   r_step, r_digit, r_last;
    logic [7:0]   r_dirty;
    logic         r_init_done, r_sel_int;
    logic [7:0]   r_buf [8][8];
    logic [W-1:0] r_frame, w_frame;
    logic         w_tick, w_done, w_found, w_pend, w_wr;
    logic [2:0]   w_idx;
    logic [7:0]   w_int_byte;

    assign w_wr = bus.wr_en && 32'(bus.wr_dev) < NUM_DEVICES;
    assign bus.init_done = r_init_done;
    assign bus.state_dbg = r_state;

`ifdef MAX7219_INTENSITY_PORT_EN
    logic [3:0] r_int, r_int_d;
    logic       r_pend;
    // Set wins over the clear in LOAD, so a change during the intensity frame sends another one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int   <= INTENSITY[3:0];
            r_int_d <= INTENSITY[3:0];
            r_pend  <= 1'b0;
        end else begin
            r_int   <= bus.intensity_in;
            r_int_d <= r_int;
            if (r_init_done && r_int != r_int_d) r_pend <= 1'b1;
            else if (w_tick && r_state == ST_LOAD && r_sel_int) r_pend <= 1'b0;
        end
    end
    assign w_pend     = r_pend;
    assign w_int_byte = {4'h0, r_int};
`else
    assign w_pend     = 1'b0;
    assign w_int_byte = INTENSITY;
`endif

    // Round-robin search from r_last+1; iterating downwards lets the nearest dirty index win.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 8; i >= 1; i--)
            if (r_dirty[r_last + 3'(i)]) begin
                w_found = 1'b1;
                w_idx   = r_last + 3'(i);
            end
    end

    // Device d's word sits at bits [16d +: 16], so the highest device is shifted out first.
    always_comb begin
        w_frame = '0;
        for (int d = 0; d < NUM_DEVICES; d++)
            w_frame[16*d +: 16] = !r_init_done ? init_word(r_step, DECODE_MODE, SCAN_LIMIT, w_int_byte) :
                                  r_sel_int    ? {REG_INTENSITY, w_int_byte} :
                                                 {REG_DIGIT0 + 8'(r_digit), r_buf[d][r_digit]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_WAIT;
            r_wcnt      <= '0;
            r_step      <= '0;
            r_digit     <= '0;
            r_last      <= 3'd7;
            r_dirty     <= 8'hFF;
            r_init_done <= 1'b0;
            r_sel_int   <= 1'b0;
            r_frame     <= '0;
        end else begin
            if (w_tick)
                case (r_state)
                    ST_WAIT: begin
                        r_wcnt <= r_wcnt + 16'd1;
                        if (r_wcnt + 16'd1 >= 16'(STARTUP_WAIT)) r_state <= ST_INIT;
                    end
                    ST_INIT: begin
                        r_frame <= w_frame;
                        r_state <= ST_SHIFT;
                    end
                    ST_SCAN: begin
                        r_sel_int <= w_pend;
                        r_digit   <= w_idx;
                        r_state   <= (w_pend || w_found) ? ST_LOAD : ST_IDLE;
                    end
                    ST_LOAD: begin
                        r_frame <= w_frame;
                        r_state <= ST_SHIFT;
                        if (!r_sel_int) begin
                            r_dirty[r_digit] <= 1'b0;
                            r_last           <= r_digit;
                        end
                    end
                    ST_SHIFT: r_state <= ST_GAP;
                    ST_GAP: if (w_done) begin
                        r_state <= ST_SCAN;
                        if (!r_init_done) begin
                            r_step <= r_step + 3'd1;
                            if (r_step == 3'd5) r_init_done <= 1'b1;
                            else r_state <= ST_INIT;
                        end
                    end
                    ST_IDLE: if (w_pend || |r_dirty) r_state <= ST_SCAN;
                    default: r_state <= ST_WAIT;
                endcase
            if (w_wr) r_dirty[bus.wr_digit] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 8; d++)
                for (int g = 0; g < 8; g++)
                    r_buf[d][g] <= 8'h00;
        end else if (w_wr) begin
            r_buf[bus.wr_dev][bus.wr_digit] <= bus.wr_data;
        end
    end

    max7219_shifter #(.NUM_DEVICES(NUM_DEVICES), .CLK_DIV(CLK_DIV)) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .i_start(r_state == ST_SHIFT),
        .i_data (r_frame),
        .o_tick (w_tick),
        .o_busy (bus.busy),
        .o_done (w_done),
        .o_din  (bus.io_din),
        .o_cs   (bus.io_cs),
        .o_clk  (bus.io_clk)
    );
endmodule

// File: tb/tb_max7219_chain.sv
// tb_max7219_chain: pin-level frame decoder checked against a frame-buffer model of the MAX7219 chain
module tb_max7219_chain;
    import max7219_pkg::*;

    localparam int N = 2, DIV = 2, SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0, n_errors = 0;
    int   rx_n = 0, nb = 0;
    logic aborted = 1'b0;
    logic [31:0] sh = '0;
    logic [31:0] exp_q[$];
    logic [31:0] rx_log[$];
    logic [7:0]  m_buf [N][8];
    logic [7:0]  m_int = 8'h00;

    max7219_chain_if bus();

    max7219_chain #(.NUM_DEVICES(N), .CLK_DIV(DIV), .STARTUP_WAIT(SW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] row_frame(input int g);
        return {8'(g + 1), m_buf[1][g], 8'(g + 1), m_buf[0][g]};
    endfunction

    // Model of what a fresh reset must produce: six broadcast init words, then all eight rows.
    task automatic push_boot();
        exp_q.push_back(32'h0C00_0C00);
        exp_q.push_back(32'h0F00_0F00);
        exp_q.push_back(32'h0900_0900);
        exp_q.push_back(32'h0B07_0B07);
        exp_q.push_back({8'h0A, m_int, 8'h0A, m_int});
        exp_q.push_back(32'h0C01_0C01);
        for (int g = 0; g < 8; g++) exp_q.push_back(row_frame(g));
    endtask

    task automatic wr(input int dev, input int digit, input logic [7:0] data);
        bus.wr_en    = 1'b1;
        bus.wr_dev   = 3'(dev);
        bus.wr_digit = 3'(digit);
        bus.wr_data  = data;
        if (dev < N) m_buf[dev][digit] = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_rx(input int k);
        int t = 0;
        while (rx_n < k && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check("frame_count", 32'(rx_n), 32'(k));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(bus.state_dbg == ST_IDLE && !bus.busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("idle_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Pin decoder and compare process: runs every cycle, away from the active edge.
    initial begin
        logic p_cs, p_clk;
        logic [31:0] e;
        p_cs  = 1'b1;
        p_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.io_cs) check("busy_while_cs_low", 32'(bus.busy), 32'd1);
            if (bus.io_cs && bus.io_clk) check("io_clk_low_when_deselected", 32'(bus.io_clk), 32'd0);
            if (p_cs && !bus.io_cs) begin
                sh = '0;
                nb = 0;
                aborted = 1'b0;
            end
            if (!bus.io_cs && !p_clk && bus.io_clk) begin
                sh = {sh[30:0], bus.io_din};
                nb++;
            end
            if (!p_cs && bus.io_cs && !aborted) begin
                rx_log.push_back(sh);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got %h expected none", sh);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_value", sh, e);
                    check("frame_bits", 32'(nb), 32'd32);
                end
                rx_n++;
            end
            p_cs  = bus.io_cs;
            p_clk = bus.io_clk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, base;
        bus.wr_en = 1'b0;
        bus.wr_dev = '0;
        bus.wr_digit = '0;
        bus.wr_data = '0;
`ifdef MAX7219_INTENSITY_PORT_EN
        bus.intensity_in = 4'd0;
`endif
        for (int d = 0; d < N; d++)
            for (int g = 0; g < 8; g++) m_buf[d][g] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_cs", 32'(bus.io_cs), 32'd1);
        check("reset_clk", 32'(bus.io_clk), 32'd0);
        check("reset_din", 32'(bus.io_din), 32'd0);
        check("reset_init_done", 32'(bus.init_done), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'(ST_WAIT));
        push_boot();
        rst = 1'b0;
        t = 0;
        while (bus.io_cs && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("startup_wait_ok", 32'(t >= SW * DIV), 32'd1);

        wait_rx(6);
        check("init_done_before_gap_end", 32'(bus.init_done), 32'd0);
        wait_rx(7);
        check("init_done_after_init", 32'(bus.init_done), 32'd1);
        check("first_frame", rx_log[0], 32'h0C00_0C00);
        check("sixth_frame", rx_log[5], 32'h0C01_0C01);
        wait_rx(14);
        check("last_boot_row", rx_log[13], 32'h0800_0800);
        wait_idle();

        wr(1, 0, 8'hA5);
        exp_q.push_back(32'h01A5_0100);
        wait_rx(15);
        wait_idle();

        wr(0, 3, 8'h11);
        wr(0, 3, 8'h22);
        exp_q.push_back(32'h0400_0422);
        wait_rx(16);
        wait_idle();

        wr(0, 2, 8'h44);
        exp_q.push_back(32'h0300_0344);
        t = 0;
        while (!bus.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("frame_started", 32'(bus.busy), 32'd1);
        wr(0, 2, 8'h33);
        exp_q.push_back(32'h0300_0333);
        wait_rx(18);
        wait_idle();

        base = rx_n;
        wr(5, 0, 8'hEE);
        repeat (300) @(negedge clk);
        check("bad_dev_no_frame", 32'(rx_n), 32'(base));
        check("bad_dev_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        wr(0, 0, 8'h00);
        exp_q.push_back(row_frame(0));
        wait_rx(base + 1);
        check("bad_dev_buffer_intact", rx_log[base], 32'h01A5_0100);
        wait_idle();

`ifdef MAX7219_INTENSITY_PORT_EN
        base = rx_n;
        bus.intensity_in = 4'd9;
        m_int = 8'h09;
        exp_q.push_back(32'h0A09_0A09);
        wait_rx(base + 1);
        wait_idle();
`endif

        wr(1, 7, 8'h5A);
        t = 0;
        while (!(!bus.io_cs && nb == 10 && !bus.io_clk) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("reached_bit10", 32'(nb), 32'd10);
        aborted = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", 32'(bus.io_cs), 32'd1);
        check("midrst_clk", 32'(bus.io_clk), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_init_done", 32'(bus.init_done), 32'd0);
        check("midrst_state", 32'(bus.state_dbg), 32'(ST_WAIT));
        for (int d = 0; d < N; d++)
            for (int g = 0; g < 8; g++) m_buf[d][g] = 8'h00;
        exp_q.delete();
        push_boot();
        base = rx_n;
        rst = 1'b0;
        wait_rx(base + 14);
        check("reinit_first_frame", rx_log[base], 32'h0C00_0C00);
        check("reinit_done", 32'(bus.init_done), 32'd1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
